// File: rtl/wave_nco_gen.sv
// wave_nco_gen: phase-accumulator NCO producing saw/triangle/square/LFSR-noise samples at a divided sample rate.
// Latency: o_sample/o_valid/o_wrap are registered and update one clock after the divider tick.
// Backpressure: none, the output is a free-running pulse stream; i_en=0 freezes all generator state.
// Optional hard sync to an external reference: define NCO_SYNC_EN to add the i_sync input.
module wave_nco_gen #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8,
  parameter int DIV_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [1:0]         i_mode,
  input  logic [PHASE_W-1:0] i_phase_step,
  input  logic               i_step_load,
  input  logic [DIV_W-1:0]   i_tick_div,
`ifdef NCO_SYNC_EN
  input  logic               i_sync,
`endif
  output logic [OUT_W-1:0]   o_sample,
  output logic               o_valid,
  output logic               o_wrap
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [DIV_W-1:0]   count;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] step_shadow;
  logic [PHASE_W-1:0] step_active;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;
  logic [PHASE_W:0]   sum;
  logic               tick;
  logic               msb;
  logic [OUT_W-1:0]   tri_t;
  logic [OUT_W-1:0]   sample_next;

  // Sync (when present) takes precedence, so a sync cycle never produces a sample.
`ifdef NCO_SYNC_EN
  assign tick = i_en && !i_sync && (count == i_tick_div);
`else
  assign tick = i_en && (count == i_tick_div);
`endif

  // Carry out of the accumulator add is the wrap flag.
  assign sum       = {1'b0, acc} + {1'b0, step_active};
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign msb       = sum[PHASE_W-1];
  assign tri_t     = sum[PHASE_W-2 -: OUT_W];

  // Waveform shaping from the post-tick accumulator and LFSR values.
  always_comb begin
    sample_next = '0;
    case (i_mode)
      2'b00:   sample_next = sum[PHASE_W-1 -: OUT_W];
      2'b01:   sample_next = msb ? ~tri_t : tri_t;
      2'b10:   sample_next = {OUT_W{msb}};
      default: sample_next = lfsr_next[OUT_W-1:0];
    endcase
  end

  // Shadow step capture runs even while disabled; a later load overwrites an unapplied one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_shadow <= '0;
    end else if (i_step_load) begin
      step_shadow <= i_phase_step;
    end
  end

  // Divider, accumulator, step hand-over and LFSR; everything advances only on a tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count       <= '0;
      acc         <= '0;
      step_active <= '0;
      lfsr        <= LFSR_SEED;
    end
`ifdef NCO_SYNC_EN
    else if (i_sync) begin
      count       <= '0;
      acc         <= '0;
      step_active <= step_shadow;
    end
`endif
    else if (i_en) begin
      if (tick) begin
        count       <= '0;
        acc         <= sum[PHASE_W-1:0];
        step_active <= step_shadow;
        lfsr        <= lfsr_next;
      end else begin
        // Lowering i_tick_div below count lets this wrap through zero rather than tick early.
        count <= count + DIV_W'(1);
      end
    end
  end

  // Registered outputs: pulses last one clock, sample holds between ticks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sample <= '0;
      o_valid  <= 1'b0;
      o_wrap   <= 1'b0;
    end else begin
      o_valid <= tick;
      o_wrap  <= tick & sum[PHASE_W];
      if (tick) begin
        o_sample <= sample_next;
      end
    end
  end

endmodule

// File: tb/tb_wave_nco_gen.sv
// Bench for wave_nco_gen: directed waveform sequences followed by randomized traffic,
// every cycle compared with an arithmetic reference model of the generator.
module tb_wave_nco_gen;

  logic        i_clk        = 1'b0;
  logic        i_rst_n      = 1'b0;
  logic        i_en         = 1'b0;
  logic [1:0]  i_mode       = 2'd0;
  logic [15:0] i_phase_step = 16'd0;
  logic        i_step_load  = 1'b0;
  logic [7:0]  i_tick_div   = 8'd0;
`ifdef NCO_SYNC_EN
  logic        i_sync       = 1'b0;
`endif
  logic [7:0]  o_sample;
  logic        o_valid;
  logic        o_wrap;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int m_acc, m_act, m_shadow, m_lfsr, m_cnt;
  int e_sample, e_valid, e_wrap;

  wave_nco_gen #(.PHASE_W(16), .OUT_W(8), .DIV_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_mode       (i_mode),
    .i_phase_step (i_phase_step),
    .i_step_load  (i_step_load),
    .i_tick_div   (i_tick_div),
`ifdef NCO_SYNC_EN
    .i_sync       (i_sync),
`endif
    .o_sample     (o_sample),
    .o_valid      (o_valid),
    .o_wrap       (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wave(input int a, input int l, input int mode);
    int t;
    case (mode)
      0: return a / 256;
      1: begin
        t = (a % 32768) / 128;
        return (a >= 32768) ? 255 - t : t;
      end
      2: return (a >= 32768) ? 255 : 0;
      default: return l % 256;
    endcase
  endfunction

  task automatic mreset();
    m_acc = 0; m_act = 0; m_shadow = 0; m_lfsr = 'hACE1; m_cnt = 0;
    e_sample = 0; e_valid = 0; e_wrap = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int new_sh, s, fb;
    if (!i_rst_n) begin
      mreset();
      return;
    end
    new_sh  = i_step_load ? int'(i_phase_step) : m_shadow;
    e_valid = 0;
    e_wrap  = 0;
    if (i_en) begin
      if (m_cnt == int'(i_tick_div)) begin
        s      = m_acc + m_act;
        e_wrap = (s >= 65536) ? 1 : 0;
        m_acc  = s % 65536;
        m_act  = m_shadow;
        fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
        e_sample = wave(m_acc, m_lfsr, int'(i_mode));
        e_valid  = 1;
        m_cnt    = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    m_shadow = new_sh;
  endtask

  task automatic cyc();
    model_step();
    @(posedge i_clk);
    #1;
    chk("valid", o_valid, e_valid);
    chk("wrap", o_wrap, e_wrap);
    chk("sample", o_sample, e_sample);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    cyc();
    i_rst_n = 1'b1;
  endtask

  task automatic load_step(input logic [15:0] st);
    i_en = 1'b0;
    i_step_load = 1'b1;
    i_phase_step = st;
    cyc();
    i_step_load = 1'b0;
  endtask

  initial begin
    int nv, held, j;
    int got[$];
    mreset();

    // Reset state
    cyc();
    cyc();
    chk("rst_sample", o_sample, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_wrap", o_wrap, 0);
    i_rst_n = 1'b1;

    // Sawtooth, tick every clock, step 0x1000
    i_mode = 2'd0; i_tick_div = 8'd0;
    load_step(16'h1000);
    i_en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cyc();
      chk("saw_valid", o_valid, 1);
      chk("saw_sample", o_sample, (k * 16) % 256);
      chk("saw_wrap", o_wrap, (k == 16) ? 1 : 0);
    end

    // Enable dropped for 10 clocks: no pulses, sample held, resumes without skipping
    held = int'(o_sample);
    i_en = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      nv += int'(o_valid);
      chk("en_hold", o_sample, held);
    end
    chk("en_novalid", nv, 0);
    i_en = 1'b1;
    cyc();
    chk("en_resume", o_sample, (held + 16) % 256);

    // Noise straight out of reset
    do_reset();
    i_mode = 2'd3; i_en = 1'b1;
    cyc();
    chk("noise_first", o_sample, 'h70);

    // Triangle, step 0x1000
    do_reset();
    i_mode = 2'd1;
    load_step(16'h1000);
    i_en = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      cyc();
      if (k == 1)  chk("tri_k1", o_sample, 'h20);
      if (k == 7)  chk("tri_k7", o_sample, 'hE0);
      if (k == 8)  chk("tri_peak", o_sample, 'hFF);
      if (k == 9)  chk("tri_k9", o_sample, 'hDF);
      if (k == 16) chk("tri_period0", o_sample, 'h00);
      if (k == 17) chk("tri_period1", o_sample, 'h20);
    end

    // Square, step 0x2000, sample every 4 clocks
    do_reset();
    i_mode = 2'd2; i_tick_div = 8'd3;
    load_step(16'h2000);
    i_en = 1'b1;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (o_valid) begin
        j = nv;
        chk("sq_spacing", k % 4, 3);
        chk("sq_sample", o_sample, ((j % 8) >= 4) ? 255 : 0);
        chk("sq_wrap", o_wrap, (j == 8) ? 1 : 0);
        nv++;
      end
    end
    chk("sq_count", nv, 10);

    // Step change mid-period: next sample still uses the old step
    do_reset();
    i_mode = 2'd0; i_tick_div = 8'd3;
    load_step(16'h1000);
    i_en = 1'b1;
    repeat (9) cyc();
    i_step_load = 1'b1; i_phase_step = 16'h0800;
    cyc();
    i_step_load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (o_valid) got.push_back(int'(o_sample));
    end
    chk("stepchg_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("stepchg_s0", got[0], 'h20);
      chk("stepchg_s1", got[1], 'h28);
      chk("stepchg_s2", got[2], 'h30);
    end
    cyc();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_sample", o_sample, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_wrap", o_wrap, 0);
    mreset();
    cyc();
    i_rst_n = 1'b1;
    repeat (6) cyc();

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      i_en = ($urandom % 8) != 0;
      if ($urandom % 6 == 0) i_mode = 2'($urandom % 4);
      i_step_load = ($urandom % 10) == 0;
      i_phase_step = 16'($urandom);
      if ($urandom % 60 == 0) i_tick_div = 8'($urandom % 4);
      if ($urandom % 700 == 0) i_rst_n = 1'b0;
      else i_rst_n = 1'b1;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
